// File: rtl/flash_pkg.sv
// Shared opcodes and FSM state encoding for the configuration-flash SPI reader.
package flash_pkg;
    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_WRSR = 8'h01;
    localparam logic [7:0] CMD_RDSR = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_DESEL
    } state_e;
endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: half-period timer with rise/fall strobes; freeze parks SCLK low.
module spi_sclk_gen #(
    parameter int SCLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic freeze,
    output logic sclk,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(SCLK_DIV + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          hold, tick;

    always_comb begin
        // A freeze only takes effect once SCLK is low, so a high phase always completes.
        hold   = freeze && !sclk_q;
        tick   = en && !hold && (cnt_q == CW'(SCLK_DIV - 1));
        rise   = tick && !sclk_q;
        fall   = tick && sclk_q;
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (tick) begin
            cnt_d  = '0;
            sclk_d = !sclk_q;
        end else if (!hold) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;
endmodule

// File: rtl/flash_reader.sv
// SPI mode-0 READ (0x03) engine: byte-range requests in, flash bytes out on valid/ready.
module flash_reader
    import flash_pkg::*;
#(
    parameter int ADDR_W   = 24,
    parameter int LEN_W    = 16,
    parameter int SCLK_DIV = 2,
    parameter int CS_HIGH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              done,
    output logic              busy,
    output logic              spi_cs,
    output logic              spi_sclk,
    output logic              spi_sclk_oe,
    output logic              spi_mosi,
    input  logic              spi_miso
);
    localparam int TX_W = 8 + ADDR_W;
    localparam int BW   = $clog2(ADDR_W + 1);
    localparam int DW   = $clog2(CS_HIGH + 1);

    state_e            state_q, state_d;
    logic [TX_W-1:0]   tx_q, tx_d;
    logic [7:0]        rx_q, rx_d, out_data_q, out_data_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [LEN_W-1:0]  left_q, left_d;
    logic [DW-1:0]     desel_q, desel_d;
    logic              out_valid_q, out_valid_d, rx_done_q, rx_done_d;
    logic              done_q, done_d, cs_q, cs_d;
    logic              accept, pop, sclk_en, freeze, rise, fall, sclk;

    assign req_ready = (state_q == ST_IDLE) && cfg_done && !done_q;
    assign accept    = req_valid && req_ready;
    assign pop       = out_valid_q && out_ready;
    assign sclk_en   = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);
    // Stall before the 8th rise of a byte while the previous byte is still unaccepted.
    assign freeze    = (state_q == ST_DATA) &&
                       (rx_done_q || ((bit_q == BW'(7)) && out_valid_q && !out_ready));

    spi_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk (
        .clk    (clk),
        .reset  (reset),
        .en     (sclk_en),
        .freeze (freeze),
        .sclk   (sclk),
        .rise   (rise),
        .fall   (fall)
    );

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        out_data_d  = out_data_q;
        bit_d       = bit_q;
        left_d      = left_q;
        desel_d     = desel_q;
        out_valid_d = out_valid_q;
        rx_done_d   = rx_done_q;
        cs_d        = cs_q;
        done_d      = 1'b0;
        if (pop) out_valid_d = 1'b0;
        if (sclk_en && fall) tx_d = tx_q << 1;
        unique case (state_q)
            ST_IDLE: if (accept) begin
                if (req_len == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d   = ST_CMD;
                    cs_d      = 1'b0;
                    tx_d      = {CMD_READ, req_addr};
                    left_d    = req_len;
                    bit_d     = '0;
                    rx_done_d = 1'b0;
                end
            end
            ST_CMD: if (rise) begin
                if (bit_q == BW'(7)) begin
                    bit_d   = '0;
                    state_d = ST_ADDR;
                end else bit_d = bit_q + 1'b1;
            end
            ST_ADDR: if (rise) begin
                if (bit_q == BW'(ADDR_W - 1)) begin
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else bit_d = bit_q + 1'b1;
            end
            ST_DATA: begin
                if (rise) begin
                    rx_d = {rx_q[6:0], spi_miso};
                    if (bit_q == BW'(7)) begin
                        out_data_d  = {rx_q[6:0], spi_miso};
                        out_valid_d = 1'b1;
                        bit_d       = '0;
                        left_d      = left_q - 1'b1;
                        if (left_q == LEN_W'(1)) rx_done_d = 1'b1;
                    end else bit_d = bit_q + 1'b1;
                end
                if (rx_done_q && !sclk && (!out_valid_q || out_ready)) begin
                    state_d = ST_DESEL;
                    cs_d    = 1'b1;
                    desel_d = '0;
                end
            end
            ST_DESEL: begin
                if (desel_q == DW'(CS_HIGH - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else desel_d = desel_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            out_data_q  <= '0;
            bit_q       <= '0;
            left_q      <= '0;
            desel_q     <= '0;
            out_valid_q <= 1'b0;
            rx_done_q   <= 1'b0;
            done_q      <= 1'b0;
            cs_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            out_data_q  <= out_data_d;
            bit_q       <= bit_d;
            left_q      <= left_d;
            desel_q     <= desel_d;
            out_valid_q <= out_valid_d;
            rx_done_q   <= rx_done_d;
            done_q      <= done_d;
            cs_q        <= cs_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign done        = done_q;
    assign busy        = (state_q != ST_IDLE) || accept;
    assign spi_cs      = cs_q;
    assign spi_sclk    = sclk;
    assign spi_sclk_oe = !cs_q;
    assign spi_mosi    = tx_q[TX_W-1];
endmodule

// File: tb/tb_flash_reader.sv
// Directed bench for flash_reader with an SPI mode-0 flash model (mem[i] = i ^ 0xA5).
module tb_flash_reader;
    logic        clk = 1'b0, reset = 1'b1, cfg_done = 1'b0, req_valid = 1'b0, out_ready = 1'b0;
    logic [23:0] req_addr = '0;
    logic [15:0] req_len = '0;
    logic        req_ready, out_valid, done, busy, spi_cs, spi_sclk, spi_sclk_oe, spi_mosi;
    logic [7:0]  out_data;
    logic        spi_miso = 1'b0;
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    flash_reader #(.SCLK_DIV(2), .CS_HIGH(4)) u_dut (
        .clk(clk), .reset(reset), .cfg_done(cfg_done), .req_valid(req_valid),
        .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .done(done),
        .busy(busy), .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_sclk_oe(spi_sclk_oe),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    // Two more instances at SCLK_DIV 1 and 3 for clock-rate and CS gap checks.
    logic            x_req_valid = 1'b0;
    logic [1:0]      x_ready, x_valid, x_done, x_busy, x_cs, x_sclk, x_oe, x_mosi;
    logic [1:0][7:0] x_data;

    flash_reader #(.SCLK_DIV(1), .CS_HIGH(4)) u_div1 (
        .clk(clk), .reset(reset), .cfg_done(1'b1), .req_valid(x_req_valid),
        .req_ready(x_ready[0]), .req_addr(24'h0), .req_len(16'd2),
        .out_valid(x_valid[0]), .out_ready(1'b1), .out_data(x_data[0]), .done(x_done[0]),
        .busy(x_busy[0]), .spi_cs(x_cs[0]), .spi_sclk(x_sclk[0]), .spi_sclk_oe(x_oe[0]),
        .spi_mosi(x_mosi[0]), .spi_miso(1'b0)
    );
    flash_reader #(.SCLK_DIV(3), .CS_HIGH(4)) u_div3 (
        .clk(clk), .reset(reset), .cfg_done(1'b1), .req_valid(x_req_valid),
        .req_ready(x_ready[1]), .req_addr(24'h0), .req_len(16'd2),
        .out_valid(x_valid[1]), .out_ready(1'b1), .out_data(x_data[1]), .done(x_done[1]),
        .busy(x_busy[1]), .spi_cs(x_cs[1]), .spi_sclk(x_sclk[1]), .spi_sclk_oe(x_oe[1]),
        .spi_mosi(x_mosi[1]), .spi_miso(1'b0)
    );

    // Flash model: shifts in opcode+address, then drives data MSB first on SCLK falls.
    int          m_cnt = 0, m_bp;
    logic [31:0] m_hdr = '0;
    logic [7:0]  m_byte;
    always @(negedge spi_cs) begin m_cnt = 0; m_hdr = '0; end
    always @(posedge spi_sclk) if (!spi_cs) begin
        if (m_cnt < 32) m_hdr = {m_hdr[30:0], spi_mosi};
        m_cnt++;
    end
    always @(negedge spi_sclk) if (!spi_cs && m_cnt >= 32) begin
        m_bp     = m_cnt - 32;
        m_byte   = (m_hdr[7:0] + 8'(m_bp / 8)) ^ 8'hA5;
        spi_miso = m_byte[7 - (m_bp % 8)];
    end

    int         rises = 0, dones = 0, cyc = 0;
    logic       cs_low = 1'b0;
    logic [7:0] got[$];
    always @(posedge spi_sclk) rises++;
    always @(posedge clk) begin
        cyc++;
        if (!reset && done) dones++;
        if (!reset && !spi_cs) cs_low = 1'b1;
        if (!reset && out_valid && out_ready) got.push_back(out_data);
    end

    int   x_last[2], x_pmin[2] = '{1000, 1000}, x_pmax[2] = '{0, 0};
    int   x_gap[2] = '{0, 0}, x_gmin[2] = '{1000, 1000}, x_dn[2] = '{0, 0};
    logic x_prev[2] = '{1'b0, 1'b0}, x_have[2] = '{1'b0, 1'b0}, x_seen[2] = '{1'b0, 1'b0};
    always @(posedge clk) if (!reset) begin
        for (int k = 0; k < 2; k++) begin
            if (x_done[k]) x_dn[k]++;
            if (x_cs[k]) begin
                x_have[k] = 1'b0;
                x_gap[k]++;
            end else begin
                if (x_seen[k] && x_gap[k] > 0 && x_gap[k] < x_gmin[k]) x_gmin[k] = x_gap[k];
                x_gap[k]  = 0;
                x_seen[k] = 1'b1;
                if (x_sclk[k] && !x_prev[k]) begin
                    if (x_have[k]) begin
                        if (cyc - x_last[k] < x_pmin[k]) x_pmin[k] = cyc - x_last[k];
                        if (cyc - x_last[k] > x_pmax[k]) x_pmax[k] = cyc - x_last[k];
                    end
                    x_have[k] = 1'b1;
                    x_last[k] = cyc;
                end
            end
            x_prev[k] = x_sclk[k];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input string tag, input logic [23:0] a, input logic [15:0] n);
        int t = 0;
        while (req_ready !== 1'b1 && t < 500) begin @(negedge clk); t++; end
        chk({tag, "_ready"}, req_ready, 1);
        req_addr  = a;
        req_len   = n;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int t = 0;
        int start = dones;
        while (dones == start && t < budget) begin @(negedge clk); t++; end
        chk(tag, dones != start, 1);
    endtask

    initial begin
        int bad, t, r0;
        logic [7:0] exp2[4] = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
        logic [7:0] exp3[3] = '{8'hA5, 8'hA4, 8'hA7};

        repeat (3) @(negedge clk);
        chk("rst_cs", spi_cs, 1);         chk("rst_sclk", spi_sclk, 0);
        chk("rst_oe", spi_sclk_oe, 0);    chk("rst_mosi", spi_mosi, 0);
        chk("rst_ready", req_ready, 0);   chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);     chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;

        // cfg_done low blocks accepts
        req_valid = 1'b1; req_len = 16'd4; bad = 0;
        repeat (100) begin @(negedge clk); if (req_ready !== 1'b0 || spi_cs !== 1'b1) bad = 1; end
        chk("cfg_gate", bad, 0);
        req_valid = 1'b0;

        // plain 4-byte read
        cfg_done = 1'b1; out_ready = 1'b1; rises = 0; dones = 0; got.delete();
        send("t2", 24'h000010, 16'd4);
        wait_done("t2_done", 2000);
        repeat (5) @(negedge clk);
        chk("t2_opcode", m_hdr[31:24], 8'h03);
        chk("t2_addr", m_hdr[23:0], 24'h000010);
        chk("t2_rises", rises, 64);
        chk("t2_dones", dones, 1);
        chk("t2_count", got.size(), 4);
        for (int i = 0; i < 4; i++) chk("t2_byte", (i < got.size()) ? got[i] : 8'hxx, exp2[i]);

        // backpressure: accept byte 0, then stall the consumer
        out_ready = 1'b0; rises = 0; dones = 0; got.delete();
        send("t3", 24'h000100, 16'd3);
        t = 0;
        while (out_valid !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
        chk("t3_b0_valid", out_valid, 1);
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
        repeat (100) @(negedge clk);
        r0 = rises;
        repeat (100) @(negedge clk);
        chk("t3_frozen", rises - r0, 0);
        chk("t3_rises", rises, 55);
        chk("t3_cs", spi_cs, 0);
        chk("t3_sclk", spi_sclk, 0);
        chk("t3_held_valid", out_valid, 1);
        chk("t3_held_data", out_data, 8'hA4);
        out_ready = 1'b1;
        wait_done("t3_done", 1000);
        repeat (3) @(negedge clk);
        chk("t3_count", got.size(), 3);
        for (int i = 0; i < 3; i++) chk("t3_byte", (i < got.size()) ? got[i] : 8'hxx, exp3[i]);
        chk("t3_dones", dones, 1);

        // zero-length request
        t = 0;
        while (req_ready !== 1'b1 && t < 500) begin @(negedge clk); t++; end
        cs_low = 1'b0; dones = 0;
        req_addr = 24'h5; req_len = 16'd0; req_valid = 1'b1;
        #1 chk("t4_busy_acc", busy, 1);
        chk("t4_ready_acc", req_ready, 1);
        @(negedge clk); req_valid = 1'b0;
        #1 chk("t4_done", done, 1);
        chk("t4_busy_after", busy, 0);
        chk("t4_ready_done", req_ready, 0);
        @(negedge clk);
        chk("t4_done_drop", done, 0);
        chk("t4_ready_back", req_ready, 1);
        chk("t4_cs_never_low", cs_low, 0);

        // reset in the middle of the address phase
        dones = 0;
        send("t5", 24'h123456, 16'd2);
        t = 0;
        while (m_cnt != 28 && t < 1000) begin @(negedge clk); t++; end
        chk("t5_reached", m_cnt, 28);
        chk("t5_hdr", m_hdr[27:0], 28'h0312345);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_cs", spi_cs, 1);
        chk("t5_sclk", spi_sclk, 0);
        chk("t5_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        chk("t5_no_done", dones, 0);
        got.delete();
        send("t5b", 24'h000000, 16'd1);
        wait_done("t5b_done", 1000);
        repeat (2) @(negedge clk);
        chk("t5b_count", got.size(), 1);
        chk("t5b_byte", (got.size() > 0) ? got[0] : 8'hxx, 8'hA5);

        // back-to-back on the SCLK_DIV=1 and =3 instances
        x_req_valid = 1'b1;
        t = 0;
        while ((x_dn[0] < 2 || x_dn[1] < 2) && t < 4000) begin @(negedge clk); t++; end
        x_req_valid = 1'b0;
        chk("t6_div1_dones", x_dn[0] >= 2, 1);
        chk("t6_div3_dones", x_dn[1] >= 2, 1);
        chk("t6_div1_pmin", x_pmin[0], 2);
        chk("t6_div1_pmax", x_pmax[0], 2);
        chk("t6_div3_pmin", x_pmin[1], 6);
        chk("t6_div3_pmax", x_pmax[1], 6);
        chk("t6_div1_gap", x_gmin[0] >= 4 && x_gmin[0] < 1000, 1);
        chk("t6_div3_gap", x_gmin[1] >= 4 && x_gmin[1] < 1000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
